multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Control FSM for the multicycle RV32I core. Sequences fetch, decode, execute, memory and writeback.
//  Drives the IR latch, immediate generator/ALU operand muxes, data-memory handshake, RF write and PC update.
//  Sits between instruction/data memory ports and the shared datapath (IR, imm generator, ALU, RF, PC).
// PARAMETERS
//  MEM_TIMEOUT   255  max wait cycles per imem/dmem request before bus-error trap; 0 = wait forever
//  RESET_ILLEGAL 0    1: illegal opcode traps; 0: illegal opcode executes as NOP (PC+4, no writes)
// PORTS
//  clk          in   1  core clock, rising edge
//  reset        in   1  asynchronous, active-high reset
//  opcode       in   7  IR[6:0], valid from DECODE onward
//  branch_taken in   1  ALU compare result, sampled in EXEC for BRANCH
//  imem_ready   in   1  instruction word valid this cycle
//  dmem_ready   in   1  data access complete this cycle
//  imem_req     out  1  instruction fetch request (held until imem_ready)
//  ir_write     out  1  latch IR; one-cycle pulse
//  dmem_req     out  1  data access request (held until dmem_ready)
//  dmem_we      out  1  1=store, valid while dmem_req
//  alu_src_a    out  2  0 rs1, 1 PC, 2 zero (LUI)
//  alu_src_b    out  1  0 rs2, 1 sextimm
//  wb_sel       out  2  0 ALU, 1 load data, 2 PC+4
//  rf_we        out  1  register-file write enable; one-cycle pulse
//  pc_write     out  1  PC update; one-cycle pulse
//  pc_src       out  2  0 PC+4, 1 PC+imm (branch/JAL), 2 (ALU result)&~1 (JALR)
//  retire       out  1  one-cycle pulse per completed instruction (same cycle as pc_write)
//  trap         out  1  sticky; core halted
//  trap_cause   out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
// BEHAVIOUR
//  States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset -> FETCH; all outputs 0, trap_cause 0.
//  FETCH: imem_req=1. On imem_ready: ir_write=1 same cycle, -> DECODE.
//  DECODE (1 cycle): classify opcode (OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC). Valid -> EXEC.
//   Illegal: RESET_ILLEGAL=1 -> TRAP(cause 1); else pc_write=1, pc_src=0, retire=1, -> FETCH.
//  EXEC (1 cycle): mux selects per class. OP: a=0,b=0. OP-IMM/LOAD/STORE/JALR: a=0,b=1. AUIPC: a=1,b=1.
//   LUI: a=2,b=1. BRANCH: a=0,b=0; pc_write=1, pc_src = branch_taken?1:0, retire=1, -> FETCH.
//   LOAD/STORE -> MEM; all others -> WB.
//  MEM: dmem_req=1, dmem_we=(STORE). On dmem_ready: STORE -> pc_write=1,pc_src=0,retire=1, -> FETCH; LOAD -> WB.
//  WB (1 cycle): rf_we=1, pc_write=1, retire=1, -> FETCH. wb_sel: LOAD 1, JAL/JALR 2, else 0.
//   pc_src: JAL 1, JALR 2, else 0. Selects held stable from EXEC through WB.
//  Latency: ALU/U/J types 4 cycles, BRANCH 3, LOAD 5, STORE 4 (zero-wait memory).
//  Timeout: wait counter clears on entering FETCH/MEM, increments each waiting cycle; when count
//   == MEM_TIMEOUT with ready still low -> TRAP (cause 2 or 3). Ready on that same cycle wins (no trap).
//  TRAP: all strobes/requests 0; trap=1; exit only via reset. First cause recorded is kept.
//  Reset mid-operation: immediate return to FETCH, requests drop asynchronously, no partial writes.
//  Opcode class registered in DECODE; opcode changes after DECODE are ignored.
// CONFIGURATION
//  MULTICYCLE_PERF_EN defined: adds outputs cycle_cnt[63:0] (increments every non-reset cycle,
//   stops in TRAP) and instret_cnt[63:0] (increments on retire); both reset to 0, wrap at 2^64.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package rv32_ctrl_pkg: RV32I opcode localparams, state encoding, alu_src/wb_sel/pc_src/
//   trap_cause code constants (shared with datapath muxes and the imm generator).
//  Sub-module opcode_classifier: combinational opcode -> one-hot class + illegal flag.
//  FSM, wait counter and optional perf counters live in multicycle_ctrl.
// TESTING
//  ADDI (0x00500093), zero-wait mem -> ir_write cyc1, rf_we+pc_write+retire cyc4, wb_sel=0, alu_src_b=1.
//  LW with dmem_ready delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, rf_we pulse with wb_sel=1.
//  BEQ taken / not taken -> pc_write at cycle 3, pc_src=1 / 0, rf_we never asserted.
//  JALR -> WB cycle: rf_we=1, wb_sel=2, pc_src=2; SW -> dmem_we=1, no rf_we, pc_src=0.
//  opcode 0x7F with RESET_ILLEGAL=1 -> TRAP, trap_cause=1, imem_req stays 0; with 0 -> retire, next FETCH.
//  MEM_TIMEOUT=4, imem_ready low -> trap_cause=2 after 5th request cycle; ready on that cycle -> no trap;
//   reset asserted mid-MEM -> FETCH, all strobes 0 immediately.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes, FSM
// state encoding, instruction-class bit positions and datapath mux codes.
package rv32_ctrl_pkg;

  // RV32I base opcodes (IR[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // One-hot instruction class bit positions
  localparam int CLS_W      = 9;
  localparam int CLS_OP     = 0;
  localparam int CLS_OPIMM  = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JAL    = 5;
  localparam int CLS_JALR   = 6;
  localparam int CLS_LUI    = 7;
  localparam int CLS_AUIPC  = 8;

  typedef logic [CLS_W-1:0] cls_t;

  // Datapath mux codes
  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;
  localparam logic       ALU_B_RS2  = 1'b0;
  localparam logic       ALU_B_IMM  = 1'b1;
  localparam logic [1:0] WB_ALU     = 2'd0;
  localparam logic [1:0] WB_MEM     = 2'd1;
  localparam logic [1:0] WB_PC4     = 2'd2;
  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_IMM     = 2'd1;
  localparam logic [1:0] PC_ALU     = 2'd2;

  // Trap cause codes
  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_IMEM    = 2'd2;
  localparam logic [1:0] TC_DMEM    = 2'd3;

  // True for classes that need a data-memory access
  function automatic logic is_mem_class(input cls_t cls);
    return cls[CLS_LOAD] | cls[CLS_STORE];
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational RV32I opcode decoder: one-hot class plus illegal flag.
module opcode_classifier
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic       illegal
);

  // Map each supported opcode onto its class bit; anything else is illegal
  always_comb begin
    cls = '0;
    case (opcode)
      OPC_OP:     cls[CLS_OP]     = 1'b1;
      OPC_OPIMM:  cls[CLS_OPIMM]  = 1'b1;
      OPC_LOAD:   cls[CLS_LOAD]   = 1'b1;
      OPC_STORE:  cls[CLS_STORE]  = 1'b1;
      OPC_BRANCH: cls[CLS_BRANCH] = 1'b1;
      OPC_JAL:    cls[CLS_JAL]    = 1'b1;
      OPC_JALR:   cls[CLS_JALR]   = 1'b1;
      OPC_LUI:    cls[CLS_LUI]    = 1'b1;
      OPC_AUIPC:  cls[CLS_AUIPC]  = 1'b1;
      default:    cls = '0;
    endcase
  end

  assign illegal = ~|cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Memory requests are bounded by a wait counter (MEM_TIMEOUT, 0 = unbounded);
// the TRAP state is sticky until reset. Defining MULTICYCLE_PERF_EN adds
// 64-bit cycle and retired-instruction counters.
module multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT   = 255,
  parameter bit          RESET_ILLEGAL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  wb_sel,
  output logic        rf_we,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 32'd1) ? $clog2(MEM_TIMEOUT + 32'd1) : 1;
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(32'd1);

  state_t            state_r, state_next_s;
  cls_t              cls_r, dec_cls_s;
  logic              dec_illegal_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              waiting_s, timeout_hit_s;
  logic [1:0]        trap_cause_r, trap_cause_next_s;
  logic [1:0]        sel_a_s, wb_sel_s, pc_src_s;
  logic              sel_b_s;

  opcode_classifier u_cls (
    .opcode  (opcode),
    .cls     (dec_cls_s),
    .illegal (dec_illegal_s)
  );

  assign waiting_s     = ((state_r == ST_FETCH) && !imem_ready) ||
                         ((state_r == ST_MEM)   && !dmem_ready);
  assign timeout_hit_s = (MEM_TIMEOUT != 32'd0) && (wait_cnt_r == TIMEOUT_V);
  assign trap_cause    = trap_cause_r;

  // State, latched instruction class and first trap cause
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_FETCH;
      cls_r        <= '0;
      trap_cause_r <= TC_NONE;
    end else begin
      state_r      <= state_next_s;
      trap_cause_r <= trap_cause_next_s;
      if (state_r == ST_DECODE) begin
        cls_r <= dec_cls_s;
      end else begin
        cls_r <= cls_r;
      end
    end
  end

  // Wait counter: counts stalled request cycles, saturates at the limit,
  // clears whenever no request is outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (waiting_s && (wait_cnt_r != TIMEOUT_V)) begin
      wait_cnt_r <= wait_cnt_r + WAIT_ONE;
    end else if (waiting_s) begin
      wait_cnt_r <= wait_cnt_r;
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Datapath selects derived from the latched class, stable EXEC..WB
  always_comb begin
    sel_a_s  = ALU_A_RS1;
    sel_b_s  = ALU_B_RS2;
    wb_sel_s = WB_ALU;
    pc_src_s = PC_PLUS4;
    if (cls_r[CLS_AUIPC]) begin
      sel_a_s = ALU_A_PC;
      sel_b_s = ALU_B_IMM;
    end else if (cls_r[CLS_LUI]) begin
      sel_a_s = ALU_A_ZERO;
      sel_b_s = ALU_B_IMM;
    end else if (cls_r[CLS_OPIMM] | cls_r[CLS_LOAD] | cls_r[CLS_STORE] | cls_r[CLS_JALR]) begin
      sel_a_s = ALU_A_RS1;
      sel_b_s = ALU_B_IMM;
    end else begin
      sel_a_s = ALU_A_RS1;
      sel_b_s = ALU_B_RS2;
    end
    if (cls_r[CLS_LOAD]) begin
      wb_sel_s = WB_MEM;
    end else if (cls_r[CLS_JAL] | cls_r[CLS_JALR]) begin
      wb_sel_s = WB_PC4;
    end else begin
      wb_sel_s = WB_ALU;
    end
    if (cls_r[CLS_JAL]) begin
      pc_src_s = PC_IMM;
    end else if (cls_r[CLS_JALR]) begin
      pc_src_s = PC_ALU;
    end else begin
      pc_src_s = PC_PLUS4;
    end
  end

  // Next-state and output decode; reset forces every output low at once
  always_comb begin
    state_next_s      = state_r;
    trap_cause_next_s = trap_cause_r;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_src_a = ALU_A_RS1;
    alu_src_b = ALU_B_RS2;
    wb_sel    = WB_ALU;
    rf_we     = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    retire    = 1'b0;
    trap      = 1'b0;
    if (reset) begin
      state_next_s = ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write     = 1'b1;
            state_next_s = ST_DECODE;
          end else if (timeout_hit_s) begin
            state_next_s      = ST_TRAP;
            trap_cause_next_s = TC_IMEM;
          end else begin
            state_next_s = ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (dec_illegal_s && RESET_ILLEGAL) begin
            state_next_s      = ST_TRAP;
            trap_cause_next_s = TC_ILLEGAL;
          end else if (dec_illegal_s) begin
            pc_write     = 1'b1;
            retire       = 1'b1;
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_src_a = sel_a_s;
          alu_src_b = sel_b_s;
          wb_sel    = wb_sel_s;
          pc_src    = pc_src_s;
          if (cls_r[CLS_BRANCH]) begin
            pc_write     = 1'b1;
            pc_src       = branch_taken ? PC_IMM : PC_PLUS4;
            retire       = 1'b1;
            state_next_s = ST_FETCH;
          end else if (is_mem_class(cls_r)) begin
            state_next_s = ST_MEM;
          end else begin
            state_next_s = ST_WB;
          end
        end
        ST_MEM: begin
          alu_src_a = sel_a_s;
          alu_src_b = sel_b_s;
          wb_sel    = wb_sel_s;
          pc_src    = pc_src_s;
          dmem_req  = 1'b1;
          dmem_we   = cls_r[CLS_STORE];
          if (dmem_ready && cls_r[CLS_STORE]) begin
            pc_write     = 1'b1;
            retire       = 1'b1;
            state_next_s = ST_FETCH;
          end else if (dmem_ready) begin
            state_next_s = ST_WB;
          end else if (timeout_hit_s) begin
            state_next_s      = ST_TRAP;
            trap_cause_next_s = TC_DMEM;
          end else begin
            state_next_s = ST_MEM;
          end
        end
        ST_WB: begin
          alu_src_a    = sel_a_s;
          alu_src_b    = sel_b_s;
          wb_sel       = wb_sel_s;
          pc_src       = pc_src_s;
          rf_we        = 1'b1;
          pc_write     = 1'b1;
          retire       = 1'b1;
          state_next_s = ST_FETCH;
        end
        ST_TRAP: begin
          trap         = 1'b1;
          state_next_s = ST_TRAP;
        end
        default: begin
          state_next_s = ST_FETCH;
        end
      endcase
    end
  end

`ifdef MULTICYCLE_PERF_EN
  // Cycle counter (frozen in TRAP) and retired-instruction counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= 64'd0;
      instret_cnt <= 64'd0;
    end else begin
      if (state_r != ST_TRAP) begin
        cycle_cnt <= cycle_cnt + 64'd1;
      end else begin
        cycle_cnt <= cycle_cnt;
      end
      if (retire) begin
        instret_cnt <= instret_cnt + 64'd1;
      end else begin
        instret_cnt <= instret_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instructions with
// scoreboarded expectations, plus hand sequences for timeouts, mid-access
// reset and the illegal-opcode trap.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode, opcode1;
  logic branch_taken, imem_ready, dmem_ready;
  logic branch_taken1, imem_ready1, dmem_ready1;
  logic imem_req, ir_write, dmem_req, dmem_we, alu_src_b, rf_we, pc_write, retire, trap;
  logic [1:0] alu_src_a, wb_sel, pc_src, trap_cause;
  logic imem_req1, ir_write1, dmem_req1, dmem_we1, alu_src_b1, rf_we1, pc_write1, retire1, trap1;
  logic [1:0] alu_src_a1, wb_sel1, pc_src1, trap_cause1;
`ifdef MULTICYCLE_PERF_EN
  logic [63:0] cycle_cnt, instret_cnt, cycle_cnt1, instret_cnt1;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [6:0] opc; logic taken; int idly; int ddly; int lat; int rf;
    logic [1:0] wb; logic [1:0] pcs; bit chk_alu; logic [1:0] a; logic b;
    int dcyc; logic we;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .RESET_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .wb_sel(wb_sel), .rf_we(rf_we),
    .pc_write(pc_write), .pc_src(pc_src), .retire(retire), .trap(trap),
    .trap_cause(trap_cause)
`ifdef MULTICYCLE_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  multicycle_ctrl #(.MEM_TIMEOUT(0), .RESET_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .opcode(opcode1), .branch_taken(branch_taken1),
    .imem_ready(imem_ready1), .dmem_ready(dmem_ready1), .imem_req(imem_req1),
    .ir_write(ir_write1), .dmem_req(dmem_req1), .dmem_we(dmem_we1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .wb_sel(wb_sel1), .rf_we(rf_we1),
    .pc_write(pc_write1), .pc_src(pc_src1), .retire(retire1), .trap(trap1),
    .trap_cause(trap_cause1)
`ifdef MULTICYCLE_PERF_EN
    , .cycle_cnt(cycle_cnt1), .instret_cnt(instret_cnt1)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Apply reset (with imem_ready high to prove strobes stay gated), release on a negedge
  task automatic do_reset();
    reset = 1'b1;
    opcode = 7'h13; branch_taken = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b0;
    opcode1 = 7'h13; branch_taken1 = 1'b0; imem_ready1 = 1'b0; dmem_ready1 = 1'b0;
    @(negedge clk); #1;
    chk("reset_outputs_zero",
        {imem_req, ir_write, dmem_req, dmem_we, alu_src_a, alu_src_b, wb_sel,
         rf_we, pc_write, pc_src, retire, trap, trap_cause}, 64'd0);
    imem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_fetch", {imem_req, trap}, {1'b1, 1'b0});
  endtask

  // Run one instruction with a reactive memory model, scoreboard its expectations
  task automatic run_vec(input int i);
    vec_t v, e;
    int cyc, ir_cyc, ret_cyc, fwait, dwait, rf_cnt, pw_cnt, dcyc;
    logic [1:0] wb_obs, pcs_obs, ex_a;
    logic ex_b, we_seen;
    bit done;
    v = vecs[i];
    sb.push_back(v);
    cyc = 0; ir_cyc = -1; ret_cyc = -1; fwait = 0; dwait = 0;
    rf_cnt = 0; pw_cnt = 0; dcyc = 0; done = 0;
    wb_obs = 2'bxx; pcs_obs = 2'bxx; ex_a = 2'bxx; ex_b = 1'bx; we_seen = 1'b0;
    opcode = v.opc; branch_taken = v.taken;
    while (!done && cyc < 60) begin
      cyc++;
      imem_ready = imem_req && (fwait == v.idly);
      if (imem_req) fwait++;
      dmem_ready = dmem_req && (dwait == v.ddly);
      if (dmem_req) dwait++;
      if (ir_cyc >= 0 && cyc > ir_cyc + 1) opcode = 7'h7F;
      #1;
      if (ir_write) ir_cyc = cyc;
      if (ir_cyc >= 0 && cyc == ir_cyc + 2) begin ex_a = alu_src_a; ex_b = alu_src_b; end
      if (dmem_req) begin dcyc++; if (dmem_we) we_seen = 1'b1; end
      if (rf_we) begin rf_cnt++; wb_obs = wb_sel; end
      if (pc_write) begin pw_cnt++; pcs_obs = pc_src; end
      if (retire) begin ret_cyc = cyc; done = 1; end
      @(negedge clk); #1;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    e = sb.pop_front();
    chk($sformatf("v%0d_retired", i), {63'd0, done}, 64'd1);
    chk($sformatf("v%0d_ir_write_cycle", i), ir_cyc, e.idly + 1);
    chk($sformatf("v%0d_latency", i), ret_cyc, e.lat);
    chk($sformatf("v%0d_rf_we_count", i), rf_cnt, e.rf);
    chk($sformatf("v%0d_pc_write_count", i), pw_cnt, 1);
    chk($sformatf("v%0d_pc_src", i), pcs_obs, e.pcs);
    if (e.rf != 0) chk($sformatf("v%0d_wb_sel", i), wb_obs, e.wb);
    if (e.chk_alu) chk($sformatf("v%0d_alu_src", i), {ex_a, ex_b}, {e.a, e.b});
    chk($sformatf("v%0d_dmem_req_cycles", i), dcyc, e.dcyc);
    chk($sformatf("v%0d_dmem_we", i), we_seen, e.we);
    chk($sformatf("v%0d_no_trap", i), trap, 1'b0);
  endtask

  // Stall memory until the timeout trap; imem answers once when first_ready is set
  task automatic hang_test(input string nm, input logic [6:0] opc, input logic first_ready,
                           input int exp_req, input int exp_trap_cyc, input logic [1:0] exp_cause);
    int req, trap_cyc, strobes;
    do_reset();
    opcode = opc; req = 0; trap_cyc = -1; strobes = 0;
    for (int c = 1; c <= 20 && trap_cyc < 0; c++) begin
      imem_ready = first_ready && (c == 1);
      dmem_ready = 1'b0;
      #1;
      if (trap) trap_cyc = c;
      if (imem_req || dmem_req) req++;
      if (rf_we || pc_write || retire) strobes++;
      @(negedge clk); #1;
    end
    imem_ready = 1'b0;
    chk({nm, "_req_cycles"}, req, exp_req);
    chk({nm, "_trap_cycle"}, trap_cyc, exp_trap_cyc);
    chk({nm, "_trap_cause"}, trap_cause, exp_cause);
    chk({nm, "_no_writes"}, strobes, 0);
    chk({nm, "_requests_low"}, {imem_req, dmem_req, trap}, {1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    int sum_lat;
    //            opc     tk    id dd lat rf wb     pcs   alu   a     b     dc we
    vecs[0]  = '{7'h13, 1'b0, 0, 0, 4,  1, 2'd0, 2'd0, 1'b1, 2'd0, 1'b1, 0, 1'b0}; // ADDI
    vecs[1]  = '{7'h03, 1'b0, 0, 3, 8,  1, 2'd1, 2'd0, 1'b1, 2'd0, 1'b1, 4, 1'b0}; // LW, 3 waits
    vecs[2]  = '{7'h63, 1'b1, 0, 0, 3,  0, 2'd0, 2'd1, 1'b1, 2'd0, 1'b0, 0, 1'b0}; // BEQ taken
    vecs[3]  = '{7'h63, 1'b0, 0, 0, 3,  0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 0, 1'b0}; // BEQ not taken
    vecs[4]  = '{7'h67, 1'b1, 0, 0, 4,  1, 2'd2, 2'd2, 1'b1, 2'd0, 1'b1, 0, 1'b0}; // JALR
    vecs[5]  = '{7'h23, 1'b0, 0, 0, 4,  0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b1, 1, 1'b1}; // SW
    vecs[6]  = '{7'h6F, 1'b0, 0, 0, 4,  1, 2'd2, 2'd1, 1'b0, 2'd0, 1'b0, 0, 1'b0}; // JAL
    vecs[7]  = '{7'h37, 1'b0, 0, 0, 4,  1, 2'd0, 2'd0, 1'b1, 2'd2, 1'b1, 0, 1'b0}; // LUI
    vecs[8]  = '{7'h17, 1'b0, 0, 0, 4,  1, 2'd0, 2'd0, 1'b1, 2'd1, 1'b1, 0, 1'b0}; // AUIPC
    vecs[9]  = '{7'h33, 1'b0, 2, 0, 6,  1, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0, 0, 1'b0}; // OP, 2 fetch waits
    vecs[10] = '{7'h7F, 1'b0, 0, 0, 2,  0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 0, 1'b0}; // illegal as NOP
    vecs[11] = '{7'h03, 1'b0, 4, 4, 13, 1, 2'd1, 2'd0, 1'b1, 2'd0, 1'b1, 5, 1'b0}; // ready at limit
    do_reset();
    sum_lat = 0;
    for (int i = 0; i < 12; i++) begin
      run_vec(i);
      sum_lat += vecs[i].lat;
    end
`ifdef MULTICYCLE_PERF_EN
    chk("perf_instret", instret_cnt, 64'd12);
    chk("perf_cycles", cycle_cnt, sum_lat);
`endif

    hang_test("imem_timeout", 7'h13, 1'b0, 5, 6, 2'd2);
    chk("dut1_waits_forever", {imem_req1, trap1}, {1'b1, 1'b0});
    hang_test("dmem_timeout", 7'h03, 1'b1, 6, 9, 2'd3);

    // Reset asserted between clock edges during the second MEM cycle of a load
    do_reset();
    opcode = 7'h03;
    for (int c = 1; c <= 5; c++) begin
      imem_ready = (c == 1);
      dmem_ready = 1'b0;
      #1;
      if (c < 5) begin
        @(negedge clk); #1;
      end
    end
    chk("midmem_in_mem", dmem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midmem_strobes_drop",
        {imem_req, ir_write, dmem_req, dmem_we, rf_we, pc_write, retire, trap}, 8'd0);
    imem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midmem_refetch", {imem_req, dmem_req}, {1'b1, 1'b0});
    run_vec(0);

    // Illegal opcode on the trapping instance
    do_reset();
    opcode1 = 7'h7F; imem_ready1 = 1'b1;
    #1;
    chk("ill_ir_write", ir_write1, 1'b1);
    @(negedge clk); #1;
    imem_ready1 = 1'b0;
    chk("ill_decode_no_retire", {pc_write1, retire1, rf_we1, trap1}, 4'd0);
    @(negedge clk); #1;
    chk("ill_trap", {trap1, trap_cause1, imem_req1}, {1'b1, 2'd1, 1'b0});
    imem_ready1 = 1'b1; opcode1 = 7'h13;
    repeat (3) begin @(negedge clk); #1; end
    chk("ill_trap_sticky", {trap1, trap_cause1, imem_req1, ir_write1}, {1'b1, 2'd1, 1'b0, 1'b0});
    imem_ready1 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
